// File: rtl/semana_pkg.sv
// Shared definitions for the weekly watering controller: day codes,
// FSM state encoding, the last hour of the day and small helpers used by
// both the day classifier and the controller itself.
package semana_pkg;

   // Day codes; 000 is not a valid day and never comes from a clean load
   localparam logic [2:0] SEG = 3'b001;
   localparam logic [2:0] TER = 3'b010;
   localparam logic [2:0] QUA = 3'b011;
   localparam logic [2:0] QUI = 3'b100;
   localparam logic [2:0] SEX = 3'b101;
   localparam logic [2:0] SAB = 3'b110;
   localparam logic [2:0] DOM = 3'b111;

   // Last valid hour of a day
   localparam logic [4:0] HORA_MAX = 5'd23;

   // Controller states; code 2'b11 is never entered
   typedef enum logic [1:0] {
      PARADO = 2'b00,
      CORRE  = 2'b01,
      REGA   = 2'b10
   } estado_t;

   // Watering days are Monday, Wednesday and Friday
   function automatic logic diaDeRega(input logic [2:0] d);
      return (d == SEG) || (d == QUA) || (d == SEX);
   endfunction

   // Day that follows d, Sunday wraps back to Monday
   function automatic logic [2:0] proximoDia(input logic [2:0] d);
      return (d == DOM) ? SEG : d + 3'd1;
   endfunction

   // Hour that follows h, 23 wraps back to 0
   function automatic logic [4:0] proximaHora(input logic [4:0] h);
      return (h >= HORA_MAX) ? 5'd0 : h + 5'd1;
   endfunction

endpackage

// File: rtl/classif_dia.sv
// Pure combinational day classifier: flags watering days (Mon/Wed/Fri)
// and Sunday. Day code 000 yields both flags low.
module classif_dia
   import semana_pkg::*;
(
   input  logic [2:0] dia_i,
   output logic       p_o,
   output logic       dom_o
);

   // Decode the day code; every code is listed so the intent is explicit
   always_comb begin
      p_o   = 1'b0;
      dom_o = 1'b0;
      case (dia_i)
         SEG, QUA, SEX: p_o   = diaDeRega(dia_i);
         TER, QUI, SAB: p_o   = 1'b0;
         DOM:           dom_o = 1'b1;
         default: begin
            p_o   = 1'b0;
            dom_o = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/controlo_semana.sv
// Weekly watering controller. Keeps a day/hour clock advanced by hourly
// ticks, opens a watering window of DURACAO hours at HORA_INI on watering
// days, and accepts day/hour loads through an edge-sensitive request with
// a one-cycle ack/err pulse.
module controlo_semana
   import semana_pkg::*;
#(
   parameter int         HORA_INI  = 6,
   parameter int         DURACAO   = 2,
   parameter logic [2:0] DIA_RESET = 3'b001
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       set_req,
   input  logic [2:0] set_dia,
   input  logic [4:0] set_hora,
   output logic       set_ack,
   output logic       set_err,
   output logic [2:0] dia,
   output logic [4:0] hora,
   output logic       p,
   output logic       dom,
   output logic       rega,
   output logic [1:0] estado
);

   localparam logic [4:0] HORA_INI_5 = 5'(HORA_INI);
   localparam logic [4:0] DURACAO_5  = 5'(DURACAO);

   estado_t    estado_q, estado_d;
   logic [2:0] dia_q, dia_d;
   logic [4:0] hora_q, hora_d;
   logic [4:0] cnt_q, cnt_d;
   logic       ack_q, ack_d;
   logic       err_q, err_d;
   logic       reqPrev_q;

   logic       amostra;
   logic       cargaValida;
   logic [4:0] horaSeg;
   logic [2:0] diaSeg;
   logic [4:0] cntSeg;

   // A request is taken only on its rising edge, so a level held high
   // after the ack/err cannot produce a second pulse until it drops
   assign amostra     = set_req & ~reqPrev_q;
   assign cargaValida = (set_dia != 3'b000) && (set_hora <= HORA_MAX);

   // Time as it would be after one tick; the day only moves at midnight
   assign horaSeg = proximaHora(hora_q);
   assign diaSeg  = (hora_q >= HORA_MAX) ? proximoDia(dia_q) : dia_q;
   assign cntSeg  = cnt_q + 5'd1;

   // Output decode of the current day
   classif_dia uClassif (
      .dia_i (dia_q),
      .p_o   (p),
      .dom_o (dom)
   );

   // Next-state logic: a sampled load has priority over any tick, and a
   // window may only open from a tick, never from a load
   always_comb begin
      estado_d = estado_q;
      dia_d    = dia_q;
      hora_d   = hora_q;
      cnt_d    = cnt_q;
      ack_d    = 1'b0;
      err_d    = 1'b0;
      if (amostra) begin
         if (cargaValida) begin
            ack_d    = 1'b1;
            dia_d    = set_dia;
            hora_d   = set_hora;
            cnt_d    = 5'd0;
            estado_d = CORRE;
         end else begin
            err_d = 1'b1;
         end
      end else begin
         case (estado_q)
            PARADO: begin
               estado_d = PARADO;
            end
            CORRE: begin
               if (tick) begin
                  hora_d = horaSeg;
                  dia_d  = diaSeg;
                  if ((horaSeg == HORA_INI_5) && diaDeRega(diaSeg)) begin
                     estado_d = REGA;
                     cnt_d    = 5'd0;
                  end
               end
            end
            REGA: begin
               if (tick) begin
                  hora_d = horaSeg;
                  dia_d  = diaSeg;
                  if (cntSeg == DURACAO_5) begin
                     estado_d = CORRE;
                     cnt_d    = 5'd0;
                  end else begin
                     cnt_d = cntSeg;
                  end
               end
            end
            default: begin
               estado_d = PARADO;
               cnt_d    = 5'd0;
            end
         endcase
      end
   end

   // State and handshake registers; reset clears everything immediately,
   // which also drops the actuator without waiting for a clock edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         estado_q  <= PARADO;
         dia_q     <= DIA_RESET;
         hora_q    <= 5'd0;
         cnt_q     <= 5'd0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         reqPrev_q <= 1'b0;
      end else begin
         estado_q  <= estado_d;
         dia_q     <= dia_d;
         hora_q    <= hora_d;
         cnt_q     <= cnt_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
         reqPrev_q <= set_req;
      end
   end

   assign set_ack = ack_q;
   assign set_err = err_q;
   assign dia     = dia_q;
   assign hora    = hora_q;
   assign rega    = (estado_q == REGA);
   assign estado  = estado_q;

endmodule

// File: tb/tb_controlo_semana.sv
// Directed bench for the weekly watering controller. Inputs change on the
// falling edge and outputs are observed on the falling edge, so each
// applyStimulus call covers exactly one rising edge of the design.
module tb_controlo_semana;

   logic       clk = 1'b0;
   logic       rst;
   logic       tick;
   logic       set_req;
   logic [2:0] set_dia;
   logic [4:0] set_hora;
   logic       set_ack;
   logic       set_err;
   logic [2:0] dia;
   logic [4:0] hora;
   logic       p;
   logic       dom;
   logic       rega;
   logic [1:0] estado;

   int nAsserts = 0;
   int nFails   = 0;
   int nAcks    = 0;

   // Free-running 10 ns clock
   always #5 clk = ~clk;

   controlo_semana #(
      .HORA_INI  (6),
      .DURACAO   (2),
      .DIA_RESET (3'b001)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick),
      .set_req  (set_req),
      .set_dia  (set_dia),
      .set_hora (set_hora),
      .set_ack  (set_ack),
      .set_err  (set_err),
      .dia      (dia),
      .hora     (hora),
      .p        (p),
      .dom      (dom),
      .rega     (rega),
      .estado   (estado)
   );

   // Compare one observed value against its hand-computed expectation
   task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      nAsserts++;
      assert (obs === exp) else begin
         nFails++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, then return inputs to idle
   task automatic applyStimulus(input logic tk, input logic rq, input logic [2:0] d, input logic [4:0] h);
      tick     = tk;
      set_req  = rq;
      set_dia  = d;
      set_hora = h;
      @(negedge clk);
      tick    = 1'b0;
      set_req = 1'b0;
   endtask

   // Linear directed sequence
   initial begin
      rst      = 1'b1;
      tick     = 1'b0;
      set_req  = 1'b0;
      set_dia  = 3'b000;
      set_hora = 5'd0;
      #3;
      checkOutput("rst_estado", 8'(estado), 8'h0);
      checkOutput("rst_dia",    8'(dia),    8'h1);
      checkOutput("rst_hora",   8'(hora),   8'h0);
      checkOutput("rst_p",      8'(p),      8'h1);
      checkOutput("rst_dom",    8'(dom),    8'h0);
      checkOutput("rst_rega",   8'(rega),   8'h0);
      checkOutput("rst_ack",    8'(set_ack), 8'h0);
      checkOutput("rst_err",    8'(set_err), 8'h0);
      @(negedge clk);
      rst = 1'b0;

      $display("[TB] ticks while stopped");
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 1'b0, 3'd0, 5'd0);
         checkOutput("parado_estado", 8'(estado), 8'h0);
         checkOutput("parado_dia",    8'(dia),    8'h1);
         checkOutput("parado_hora",   8'(hora),   8'h0);
         checkOutput("parado_p",      8'(p),      8'h1);
         checkOutput("parado_rega",   8'(rega),   8'h0);
      end

      $display("[TB] load Sunday 23h and cross midnight");
      applyStimulus(1'b0, 1'b1, 3'd7, 5'd23);
      checkOutput("dom_ack",    8'(set_ack), 8'h1);
      checkOutput("dom_err",    8'(set_err), 8'h0);
      checkOutput("dom_estado", 8'(estado),  8'h1);
      checkOutput("dom_dia",    8'(dia),     8'h7);
      checkOutput("dom_hora",   8'(hora),    8'd23);
      checkOutput("dom_dom",    8'(dom),     8'h1);
      checkOutput("dom_p",      8'(p),       8'h0);
      applyStimulus(1'b1, 1'b0, 3'd0, 5'd0);
      checkOutput("wrap_ack",  8'(set_ack), 8'h0);
      checkOutput("wrap_dia",  8'(dia),     8'h1);
      checkOutput("wrap_hora", 8'(hora),    8'h0);
      checkOutput("wrap_p",    8'(p),       8'h1);
      checkOutput("wrap_dom",  8'(dom),     8'h0);

      $display("[TB] Wednesday window");
      applyStimulus(1'b0, 1'b1, 3'd3, 5'd5);
      checkOutput("qua_ack",  8'(set_ack), 8'h1);
      checkOutput("qua_rega", 8'(rega),    8'h0);
      applyStimulus(1'b1, 1'b0, 3'd0, 5'd0);
      checkOutput("qua_h6_hora",   8'(hora),   8'd6);
      checkOutput("qua_h6_rega",   8'(rega),   8'h1);
      checkOutput("qua_h6_estado", 8'(estado), 8'h2);
      applyStimulus(1'b1, 1'b0, 3'd0, 5'd0);
      checkOutput("qua_h7_hora", 8'(hora), 8'd7);
      checkOutput("qua_h7_rega", 8'(rega), 8'h1);
      applyStimulus(1'b1, 1'b0, 3'd0, 5'd0);
      checkOutput("qua_h8_hora",   8'(hora),   8'd8);
      checkOutput("qua_h8_rega",   8'(rega),   8'h0);
      checkOutput("qua_h8_estado", 8'(estado), 8'h1);

      $display("[TB] non-watering days");
      applyStimulus(1'b0, 1'b1, 3'd2, 5'd5);
      checkOutput("ter_ack", 8'(set_ack), 8'h1);
      applyStimulus(1'b1, 1'b0, 3'd0, 5'd0);
      checkOutput("ter_hora", 8'(hora), 8'd6);
      checkOutput("ter_p",    8'(p),    8'h0);
      checkOutput("ter_rega", 8'(rega), 8'h0);
      applyStimulus(1'b0, 1'b1, 3'd7, 5'd5);
      checkOutput("dom2_ack", 8'(set_ack), 8'h1);
      applyStimulus(1'b1, 1'b0, 3'd0, 5'd0);
      checkOutput("dom2_hora",   8'(hora),   8'd6);
      checkOutput("dom2_dom",    8'(dom),    8'h1);
      checkOutput("dom2_rega",   8'(rega),   8'h0);
      checkOutput("dom2_estado", 8'(estado), 8'h1);

      $display("[TB] load straight into the window hour");
      applyStimulus(1'b0, 1'b1, 3'd1, 5'd6);
      checkOutput("load6_ack",  8'(set_ack), 8'h1);
      checkOutput("load6_rega", 8'(rega),    8'h0);
      applyStimulus(1'b0, 1'b0, 3'd0, 5'd0);
      checkOutput("load6_estado", 8'(estado), 8'h1);
      checkOutput("load6_rega2",  8'(rega),   8'h0);

      $display("[TB] rejected loads");
      applyStimulus(1'b0, 1'b1, 3'd0, 5'd3);
      checkOutput("err_dia0_err",  8'(set_err), 8'h1);
      checkOutput("err_dia0_ack",  8'(set_ack), 8'h0);
      checkOutput("err_dia0_dia",  8'(dia),     8'h1);
      checkOutput("err_dia0_hora", 8'(hora),    8'd6);
      applyStimulus(1'b0, 1'b0, 3'd0, 5'd0);
      checkOutput("err_gap_err", 8'(set_err), 8'h0);
      applyStimulus(1'b0, 1'b1, 3'd4, 5'd24);
      checkOutput("err_h24_err",  8'(set_err), 8'h1);
      checkOutput("err_h24_ack",  8'(set_ack), 8'h0);
      checkOutput("err_h24_dia",  8'(dia),     8'h1);
      checkOutput("err_h24_hora", 8'(hora),    8'd6);
      applyStimulus(1'b0, 1'b0, 3'd0, 5'd0);

      $display("[TB] request held high");
      nAcks    = 0;
      set_req  = 1'b1;
      set_dia  = 3'd2;
      set_hora = 5'd3;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         nAcks += int'(set_ack);
      end
      set_req = 1'b0;
      @(negedge clk);
      nAcks += int'(set_ack);
      checkOutput("held_pulses", 8'(nAcks), 8'd1);
      checkOutput("held_dia",    8'(dia),   8'h2);
      checkOutput("held_hora",   8'(hora),  8'd3);

      $display("[TB] load during a window");
      applyStimulus(1'b0, 1'b1, 3'd3, 5'd5);
      checkOutput("abort_ack", 8'(set_ack), 8'h1);
      applyStimulus(1'b1, 1'b0, 3'd0, 5'd0);
      checkOutput("abort_pre_rega", 8'(rega), 8'h1);
      applyStimulus(1'b1, 1'b1, 3'd5, 5'd10);
      checkOutput("abort_ack2",   8'(set_ack), 8'h1);
      checkOutput("abort_hora",   8'(hora),    8'd10);
      checkOutput("abort_dia",    8'(dia),     8'h5);
      checkOutput("abort_estado", 8'(estado),  8'h1);
      checkOutput("abort_rega",   8'(rega),    8'h0);
      applyStimulus(1'b1, 1'b0, 3'd0, 5'd0);
      checkOutput("abort_next_hora",   8'(hora),   8'd11);
      checkOutput("abort_next_estado", 8'(estado), 8'h1);

      $display("[TB] reset in the middle of a window");
      applyStimulus(1'b0, 1'b1, 3'd3, 5'd5);
      applyStimulus(1'b1, 1'b0, 3'd0, 5'd0);
      checkOutput("midrst_pre_rega", 8'(rega), 8'h1);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("midrst_rega",   8'(rega),   8'h0);
      checkOutput("midrst_estado", 8'(estado), 8'h0);
      checkOutput("midrst_dia",    8'(dia),    8'h1);
      checkOutput("midrst_hora",   8'(hora),   8'h0);
      @(negedge clk);
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule

// File: doc/controlo_semana.md
CONTROLO_SEMANA -- requirements
Module: controlo_semana

Interface
REQ-001 Parameter HORA_INI, default 6, meaning: hour (0..23) at which a watering window opens.
REQ-002 Parameter DURACAO, default 2, meaning: window length in hour ticks (1..23).
REQ-003 Parameter DIA_RESET, default 3'b001, meaning: day code loaded by reset (Monday).
REQ-004 Clock and reset: one clock, clk, all state on its rising edge; reset rst is asynchronous and active-high.
REQ-005 clk  input  1  system clock.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 tick  input  1  one-cycle pulse, one hour elapsed.
REQ-008 set_req  input  1  level request to load day/hour.
REQ-009 set_dia  input  3  day to load (001=Mon … 111=Sun).
REQ-010 set_hora  input  5  hour to load.
REQ-011 set_ack  output  1  one-cycle pulse, load accepted.
REQ-012 set_err  output  1  one-cycle pulse, load rejected.
REQ-013 dia  output  3  current day code.
REQ-014 hora  output  5  current hour 0..23.
REQ-015 p  output  1  current day is Mon, Wed or Fri.
REQ-016 dom  output  1  current day is Sunday.
REQ-017 rega  output  1  watering actuator enable.
REQ-018 estado  output  2  FSM state code.

Function
REQ-019 The FSM SHALL have the states PARADO=00, CORRE=01 and REGA=10; code 11 SHALL be unreachable and SHALL fall to PARADO.
REQ-020 In PARADO, tick SHALL be ignored; a valid load SHALL move the FSM to CORRE.
REQ-021 In CORRE/REGA, each tick SHALL advance hora by 1; on hora 23, hora SHALL wrap to 0 and dia SHALL advance, with 111 wrapping to 001.
REQ-022 p SHALL be 1 for dia 001/011/101 and dom SHALL be 1 for dia 111; both SHALL be combinational decodes of the dia register, 0 for dia 000.
REQ-023 CORRE→REGA SHALL occur on the cycle after a tick that makes hora==HORA_INI while p==1; rega SHALL equal (estado==REGA).
REQ-024 In REGA, a 5-bit counter SHALL count ticks; after DURACAO ticks the FSM SHALL return to CORRE, including when the window crosses midnight or a day change.
REQ-025 A set_req high in a cycle where no ack/err was issued the previous cycle SHALL be sampled; set_ack or set_err SHALL pulse exactly one cycle later.
REQ-026 set_req held high after an ack/err SHALL NOT produce a second pulse until it has been low for at least one cycle.
REQ-027 A load with set_dia==000 or set_hora>23 SHALL pulse set_err and leave all state unchanged.
REQ-028 A valid load SHALL write dia/hora with the ack, clear the REGA counter, and force the FSM to CORRE, aborting any window in progress.
REQ-029 When a tick and a sampled load coincide, the load SHALL win and the tick SHALL be dropped.
REQ-030 A window SHALL NOT open because of a load: a load to hora==HORA_INI SHALL NOT trigger REGA.

Reset
REQ-031 While rst=1: estado=PARADO, dia=DIA_RESET, hora=0, counter=0, set_ack=0, set_err=0, rega=0; p/dom follow dia (p=1, dom=0).
REQ-032 Reset asserted mid-window SHALL drop rega asynchronously, without waiting for a clock edge.

Structure
REQ-033 The day codes SEG..DOM, the FSM state codes and the constant 23 SHALL be in the shared package semana_pkg.
REQ-034 The p/dom decode SHALL be the sub-module classif_dia (3-bit in, p/dom out, combinational).

Verification
REQ-035 Reset, then tick ×5 -> estado=00, dia=001, hora=0, p=1, rega=0 throughout.
REQ-036 Load dia=111 hora=23, then tick -> ack after 1 cycle, estado=01, dom=1; after the tick, dia=001, hora=0, p=1.
REQ-037 Load dia=011 hora=5, then tick (hora=6) -> next cycle rega=1; after 2 more ticks rega=0 with hora=8.
REQ-038 Load dia=010 hora=5, then tick -> hora=6, p=0, rega stays 0; repeat with dia=111 -> rega stays 0.
REQ-039 Load dia=000 and separately hora=24 -> set_err pulses, dia/hora unchanged; set_req held high for 4 cycles -> exactly one pulse.
REQ-040 During REGA, a tick coincident with a valid load dia=101 hora=10 -> ack, hora=10, estado=01, rega=0; assert rst mid-window -> rega=0 immediately.
